jelly2_mdio_master: RTL

JELLY2_MDIO_MASTER -- requirements
Module: jelly2_mdio_master

---
 rtl/jelly2_mdio_master.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/jelly2_mdio_master.sv
// Purpose : IEEE 802.3 clause-22 MDIO master; one read or write frame per accepted command.
// Latency : first bit launches with the accept edge; m_valid after PREAMBLE_LEN+32 bit periods, s_ready one bit period later.
// Backpressure: s_ready is high only while idle; s_valid during a frame is ignored, nothing is queued.
//
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   s_op/s_phyad/s_regad/s_wdata        command (op 0=write, 1=read), captured on s_valid && s_ready
//   s_valid/s_ready                     command handshake
//   m_rdata/m_err/m_valid               completion: read data, turnaround error, one-cycle pulse
//   busy                                frame in progress
//   mdc, mdio_o/mdio_t/mdio_i           management clock and tristate MDIO pin (mdio_t=1 releases)
module jelly2_mdio_master #(
    parameter int CLK_DIV      = 25,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_op,
    input  logic [4:0]  s_phyad,
    input  logic [4:0]  s_regad,
    input  logic [15:0] s_wdata,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] m_rdata,
    output logic        m_err,
    output logic        m_valid,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HEADER,
        ST_TA,
        ST_DATA,
        ST_GAP
    } state_t;

    // Divider spans a whole bit period (up to 2*255-1), so it never wraps mid-bit.
    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] BIT_LAST  = 9'(2 * CLK_DIV - 1);
    localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_LEN - 1);

    state_t      state;
    logic [8:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic        op_q;
    logic [13:0] hdr_q;     // ST, OP, PHYAD, REGAD; shifted out from bit 13
    logic [15:0] wdata_q;   // shifted out from bit 15
    logic [15:0] rd_sr;
    logic        ta_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            op_q    <= 1'b0;
            hdr_q   <= '0;
            wdata_q <= '0;
            rd_sr   <= '0;
            ta_err  <= 1'b0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            m_valid <= 1'b0;
            m_rdata <= '0;
            m_err   <= 1'b0;
            mdc     <= 1'b0;
            mdio_o  <= 1'b1;
            mdio_t  <= 1'b1;
        end else begin
            m_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    s_ready <= 1'b1;
                    mdc     <= 1'b0;
                    mdio_o  <= 1'b1;
                    mdio_t  <= 1'b1;
                    if (s_valid && s_ready) begin
                        // The accept edge also launches the first preamble bit.
                        op_q    <= s_op;
                        hdr_q   <= {2'b01, (s_op ? 2'b10 : 2'b01), s_phyad, s_regad};
                        wdata_q <= s_wdata;
                        state   <= ST_PREAMBLE;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                        mdio_t  <= 1'b0;
                        mdio_o  <= 1'b1;
                    end
                end
                default: begin
                    if (div_cnt == HALF_LAST) begin
                        // mdc rises on this edge; the PHY's bit is sampled on the same edge.
                        mdc     <= 1'b1;
                        div_cnt <= div_cnt + 9'd1;
                        if (op_q && state == ST_TA && bit_cnt == 6'd1)
                            ta_err <= mdio_i;
                        if (op_q && state == ST_DATA)
                            rd_sr <= {rd_sr[14:0], mdio_i};
                    end else if (div_cnt == BIT_LAST) begin
                        // mdc falls: the only place the pin drive may change.
                        mdc     <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 6'd1;
                        case (state)
                            ST_PREAMBLE: begin
                                if (bit_cnt == PRE_LAST) begin
                                    state   <= ST_HEADER;
                                    bit_cnt <= '0;
                                    mdio_o  <= hdr_q[13];
                                    hdr_q   <= {hdr_q[12:0], 1'b0};
                                end else begin
                                    mdio_o  <= 1'b1;
                                end
                            end
                            ST_HEADER: begin
                                if (bit_cnt == 6'd13) begin
                                    // First TA bit: write drives 1, read releases the line.
                                    state   <= ST_TA;
                                    bit_cnt <= '0;
                                    mdio_o  <= 1'b1;
                                    mdio_t  <= op_q;
                                end else begin
                                    mdio_o  <= hdr_q[13];
                                    hdr_q   <= {hdr_q[12:0], 1'b0};
                                end
                            end
                            ST_TA: begin
                                if (bit_cnt == 6'd1) begin
                                    state   <= ST_DATA;
                                    bit_cnt <= '0;
                                    mdio_o  <= op_q ? 1'b1 : wdata_q[15];
                                    wdata_q <= {wdata_q[14:0], 1'b0};
                                end else begin
                                    mdio_o  <= op_q;
                                end
                            end
                            ST_DATA: begin
                                if (bit_cnt == 6'd15) begin
                                    state   <= ST_GAP;
                                    bit_cnt <= '0;
                                    mdio_o  <= 1'b1;
                                    mdio_t  <= 1'b1;
                                    m_valid <= 1'b1;
                                    m_rdata <= op_q ? rd_sr : 16'h0000;
                                    m_err   <= op_q ? ta_err : 1'b0;
                                end else begin
                                    mdio_o  <= op_q ? 1'b1 : wdata_q[15];
                                    wdata_q <= {wdata_q[14:0], 1'b0};
                                end
                            end
                            default: begin
                                // End of the gap bit.
                                state   <= ST_IDLE;
                                bit_cnt <= '0;
                                s_ready <= 1'b1;
                                busy    <= 1'b0;
                                mdio_o  <= 1'b1;
                                mdio_t  <= 1'b1;
                            end
                        endcase
                    end else begin
                        div_cnt <= div_cnt + 9'd1;
                    end
                end
            endcase
        end
    end

endmodule
